// File: rtl/prog_pkg.sv
//------------------------------------------------------------------------------
// Module      : prog_pkg
// Description : Shared state encoding and block-type constants for the
//               program block sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prog_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_REQ      = 3'd1,
    SEQ_ACK      = 3'd2,
    SEQ_WAIT     = 3'd3,
    SEQ_DISPATCH = 3'd4,
    SEQ_STREAM   = 3'd5,
    SEQ_DONE     = 3'd6,
    SEQ_ERR      = 3'd7
  } seq_state_t;

  localparam logic [7:0] BLK_TYPE_DATA = 8'h00;
  localparam logic [7:0] BLK_TYPE_EOF  = 8'h01;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_block_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : program_block_sequencer_if
// Description : Byte-write port (address, data, last) with valid/ready
//               handshake toward the NVM write engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface program_block_sequencer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_last;

  modport master (output wr_valid, wr_addr, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_last, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/program_block_sequencer.sv
//------------------------------------------------------------------------------
// Module      : program_block_sequencer
// Description : Requests decoded blocks one at a time and streams data-block
//               bytes as address/data writes until an EOF block arrives.
//               Optional feature macro: PROG_CHECKSUM_EN (running byte sum).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module program_block_sequencer
  import prog_pkg::*;
#(
  parameter int DATA_BLOCK_MAX_SIZE = 64,
  parameter int IDX_BITS            = $clog2(DATA_BLOCK_MAX_SIZE) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 finished,
  output logic                                 error,
  output logic                                 dec_start,
  input  logic                                 dec_ready,
  input  logic                                 dec_done,
  input  logic [7:0]                           blk_length,
  input  logic [15:0]                          blk_address,
  input  logic [7:0]                           blk_type,
  input  logic [DATA_BLOCK_MAX_SIZE-1:0][7:0]  blk_data,
  program_block_sequencer_if.master            wr,
  output logic [15:0]                          blocks_written,
  output logic [15:0]                          checksum
);

  localparam logic [8:0] MAX_LEN = 9'(DATA_BLOCK_MAX_SIZE);

  seq_state_t          state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                finished_q, finished_d;
  logic                error_q, error_d;
  logic                dec_start_q, dec_start_d;
  logic                wr_valid_q, wr_valid_d;
  logic [15:0]         blocks_q, blocks_d;

  logic [IDX_BITS-2:0] byte_sel;
  logic [7:0]          cur_byte;
  logic                is_last;
  logic                hs;
  logic                stats_clr;
  logic                len_bad;
  logic                addr_ovf;
  logic                idle_like;

  assign byte_sel  = idx_q[IDX_BITS-2:0];
  assign cur_byte  = blk_data[byte_sel];
  assign is_last   = (8'(idx_q) == (blk_length - 8'd1));
  assign idle_like = (state_q == SEQ_IDLE) || (state_q == SEQ_DONE) || (state_q == SEQ_ERR);
  assign hs        = (state_q == SEQ_STREAM) && wr_valid_q && wr.wr_ready;
  assign stats_clr = idle_like && start && !abort;
  assign len_bad   = ({1'b0, blk_length} > MAX_LEN);
  // 17-bit sum so a block ending exactly at 0xFFFF is legal but wrapping is not
  assign addr_ovf  = (({1'b0, blk_address} + {9'd0, blk_length}) > 17'h10000);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    finished_d  = finished_q;
    error_d     = error_q;
    dec_start_d = 1'b0;
    wr_valid_d  = wr_valid_q;
    blocks_d    = blocks_q;

    case (state_q)
      SEQ_IDLE, SEQ_DONE, SEQ_ERR: begin
        if (stats_clr) begin
          finished_d = 1'b0;
          error_d    = 1'b0;
          blocks_d   = '0;
          state_d    = SEQ_REQ;
        end
      end
      SEQ_REQ: begin
        if (dec_ready) begin
          dec_start_d = 1'b1;
          state_d     = SEQ_ACK;
        end
      end
      SEQ_ACK: begin
        if (!dec_ready) state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (dec_done) state_d = SEQ_DISPATCH;
      end
      SEQ_DISPATCH: begin
        if (blk_type == BLK_TYPE_EOF) begin
          finished_d = 1'b1;
          state_d    = SEQ_DONE;
        end else if (len_bad || ((blk_type == BLK_TYPE_DATA) && addr_ovf)) begin
          error_d = 1'b1;
          state_d = SEQ_ERR;
        end else if ((blk_type == BLK_TYPE_DATA) && (blk_length == 8'd0)) begin
          blocks_d = sat_inc16(blocks_q);
          state_d  = SEQ_REQ;
        end else if (blk_type == BLK_TYPE_DATA) begin
          idx_d      = '0;
          wr_valid_d = 1'b1;
          state_d    = SEQ_STREAM;
        end else begin
          state_d = SEQ_REQ;
        end
      end
      SEQ_STREAM: begin
        if (hs) begin
          if (is_last) begin
            wr_valid_d = 1'b0;
            idx_d      = '0;
            blocks_d   = sat_inc16(blocks_q);
            state_d    = SEQ_REQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // A byte that handshakes on the abort cycle still counts
    if (abort) begin
      state_d     = SEQ_IDLE;
      wr_valid_d  = 1'b0;
      dec_start_d = 1'b0;
      idx_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEQ_IDLE;
      idx_q       <= '0;
      finished_q  <= 1'b0;
      error_q     <= 1'b0;
      dec_start_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      blocks_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      finished_q  <= finished_d;
      error_q     <= error_d;
      dec_start_q <= dec_start_d;
      wr_valid_q  <= wr_valid_d;
      blocks_q    <= blocks_d;
    end
  end

  assign busy           = !idle_like;
  assign finished       = finished_q;
  assign error          = error_q;
  assign dec_start      = dec_start_q;
  assign blocks_written = blocks_q;

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_valid_q ? (blk_address + 16'(idx_q)) : 16'h0000;
  assign wr.wr_data  = wr_valid_q ? cur_byte : 8'h00;
  assign wr.wr_last  = wr_valid_q && is_last;

`ifdef PROG_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (stats_clr) csum_d = '0;
    if (hs)        csum_d = csum_q + {8'h00, cur_byte};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= '0;
    else      csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_block_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_program_block_sequencer
// Description : Self-checking bench with a behavioural decoder and a
//               write-port scoreboard for program_block_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_block_sequencer;
  import prog_pkg::*;

  localparam int N = 64;
`ifdef PROG_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0]        len;
    logic [15:0]       addr;
    logic [7:0]        typ;
    logic [N-1:0][7:0] data;
  } blk_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              finished;
  logic              error;
  logic              dec_start;
  logic              dec_ready = 1'b1;
  logic              dec_done  = 1'b0;
  logic [7:0]        blk_length  = '0;
  logic [15:0]       blk_address = '0;
  logic [7:0]        blk_type    = '0;
  logic [N-1:0][7:0] blk_data    = '0;
  logic [15:0]       blocks_written;
  logic [15:0]       checksum;

  program_block_sequencer_if wr_if();

  program_block_sequencer #(.DATA_BLOCK_MAX_SIZE(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .finished       (finished),
    .error          (error),
    .dec_start      (dec_start),
    .dec_ready      (dec_ready),
    .dec_done       (dec_done),
    .blk_length     (blk_length),
    .blk_address    (blk_address),
    .blk_type       (blk_type),
    .blk_data       (blk_data),
    .wr             (wr_if),
    .blocks_written (blocks_written),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  blk_t        blk_q[$];
  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_count = 0;
  logic [15:0] exp_csum = '0;
  bit          hold_ready = 1'b0;
  int          stop_after = -1;
  int          stall_left = 0;
  logic [15:0] stall_addr = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Decoder: drops ready on request, delivers the next queued block 3 cycles later
  int dcnt = 0;
  bit dbusy = 1'b0;
  always @(negedge clk) begin : p_dec
    blk_t b;
    if (!dbusy) begin
      dec_done = 1'b0;
      if (dec_start) begin
        dec_ready = 1'b0;
        dbusy     = 1'b1;
        dcnt      = 3;
      end
    end else begin
      dcnt--;
      if (dcnt == 0) begin
        if (blk_q.size() > 0) begin
          b = blk_q.pop_front();
        end else begin
          b.len = 8'd0; b.addr = 16'h0; b.typ = BLK_TYPE_EOF; b.data = '0;
        end
        blk_length  = b.len;
        blk_address = b.addr;
        blk_type    = b.typ;
        blk_data    = b.data;
        dec_done    = 1'b1;
        dec_ready   = 1'b1;
        dbusy       = 1'b0;
      end
    end
  end

  // Write-port monitor: inputs set here hold through the next rising edge
  always @(negedge clk) begin : p_mon
    wr_t w;
    logic rdy;
    if (hold_ready || (stop_after >= 0 && wr_count >= stop_after)) begin
      rdy = 1'b0;
    end else if (wr_if.wr_valid && stall_left > 0 && wr_if.wr_addr == stall_addr) begin
      rdy = 1'b0;
      stall_left--;
      if (exp_q.size() > 0) begin
        chk("bp_addr", 32'(wr_if.wr_addr), 32'(exp_q[0].addr));
        chk("bp_data", 32'(wr_if.wr_data), 32'(exp_q[0].data));
      end
    end else begin
      rdy = 1'b1;
    end
    wr_if.wr_ready = rdy;
    if (wr_if.wr_valid && rdy) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 32'(wr_if.wr_addr), 32'hFFFFFFFF);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", 32'(wr_if.wr_addr), 32'(w.addr));
        chk("wr_data", 32'(wr_if.wr_data), 32'(w.data));
        chk("wr_last", 32'(wr_if.wr_last), 32'(w.last));
        exp_csum = exp_csum + {8'h00, w.data};
      end
    end
  end

  task automatic add_blk(input logic [7:0] len, input logic [15:0] addr,
                         input logic [7:0] typ, input logic [N-1:0][7:0] d,
                         input int n_exp);
    blk_t b;
    wr_t  w;
    b.len = len; b.addr = addr; b.typ = typ; b.data = d;
    blk_q.push_back(b);
    for (int i = 0; i < n_exp; i++) begin
      w.addr = addr + 16'(i);
      w.data = d[i];
      w.last = (i == int'(len) - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_seq(input string tag);
    @(negedge clk);
    exp_csum = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_idle(tag);
  endtask

  task automatic end_chk(input string tag, input int blocks, input int fin,
                         input int err, input int nwr, input int base);
    chk({tag, "_blocks"}, 32'(blocks_written), 32'(blocks));
    chk({tag, "_finished"}, 32'(finished), 32'(fin));
    chk({tag, "_error"}, 32'(error), 32'(err));
    chk({tag, "_nwrites"}, 32'(wr_count - base), 32'(nwr));
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_csum"}, 32'(checksum), CSUM_ON ? 32'(exp_csum) : 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_finished"}, 32'(finished), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_dec_start"}, 32'(dec_start), 32'd0);
    chk({tag, "_wr_valid"}, 32'(wr_if.wr_valid), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_if.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_if.wr_data), 32'd0);
    chk({tag, "_wr_last"}, 32'(wr_if.wr_last), 32'd0);
    chk({tag, "_blocks"}, 32'(blocks_written), 32'd0);
    chk({tag, "_csum"}, 32'(checksum), 32'd0);
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : p_main
    logic [N-1:0][7:0] d3;
    logic [N-1:0][7:0] d;
    int base;

    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    d3 = '0; d3[0] = 8'hAA; d3[1] = 8'hBB; d3[2] = 8'hCC;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // One data block then EOF, ready always high
    base = wr_count;
    add_blk(8'd3, 16'h8000, BLK_TYPE_DATA, d3, 3);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s1");
    end_chk("s1", 1, 1, 0, 3, base);
    chk("s1_csum_const", 32'(checksum), CSUM_ON ? 32'h0231 : 32'd0);

    // Back-pressure on the second byte
    base = wr_count;
    stall_addr = 16'h8001;
    stall_left = 5;
    add_blk(8'd3, 16'h8000, BLK_TYPE_DATA, d3, 3);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s2");
    end_chk("s2", 1, 1, 0, 3, base);
    chk("s2_stall_used", 32'(stall_left), 32'd0);

    // Zero-length data block and unknown type
    base = wr_count;
    add_blk(8'd0, 16'h8000, BLK_TYPE_DATA, '0, 0);
    add_blk(8'd2, 16'h1234, 8'h04, d3, 0);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s3");
    end_chk("s3", 1, 1, 0, 0, base);

    // Address overflow
    base = wr_count;
    add_blk(8'd3, 16'hFFFE, BLK_TYPE_DATA, d3, 0);
    run_seq("s4");
    end_chk("s4", 0, 0, 1, 0, base);

    // Oversized block
    base = wr_count;
    add_blk(8'd65, 16'h0000, BLK_TYPE_DATA, d3, 0);
    run_seq("s4b");
    end_chk("s4b", 0, 0, 1, 0, base);

    // Full-size block ending exactly at 0xFFFF
    base = wr_count;
    for (int i = 0; i < N; i++) d[i] = 8'((i * 7) + 3);
    add_blk(8'd64, 16'hFFC0, BLK_TYPE_DATA, d, N);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s4c");
    end_chk("s4c", 1, 1, 0, N, base);

    // Abort after two of four bytes
    base = wr_count;
    d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    add_blk(8'd4, 16'h4000, BLK_TYPE_DATA, d, 2);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    stop_after = base + 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && wr_count < base + 2; i++) @(negedge clk);
    chk("s5_two_bytes", 32'(wr_count - base), 32'd2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    chk("s5_blocks", 32'(blocks_written), 32'd0);
    chk("s5_finished", 32'(finished), 32'd0);
    chk("s5_exp_left", 32'(exp_q.size()), 32'd0);
    stop_after = -1;
    blk_q.delete();
    exp_q.delete();
    base = wr_count;
    add_blk(8'd3, 16'h8000, BLK_TYPE_DATA, d3, 3);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s5r");
    end_chk("s5r", 1, 1, 0, 3, base);

    // Asynchronous reset while waiting for the decoder
    add_blk(8'd3, 16'h8000, BLK_TYPE_DATA, d3, 0);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !dec_start; i++) @(negedge clk);
    chk("s6_dec_start", 32'(dec_start), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("s6_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    blk_q.delete();
    exp_q.delete();
    base = wr_count;
    add_blk(8'd3, 16'h8000, BLK_TYPE_DATA, d3, 3);
    add_blk(8'd0, 16'h0000, BLK_TYPE_EOF, '0, 0);
    run_seq("s6");
    end_chk("s6", 1, 1, 0, 3, base);
    chk("s6_csum_const", 32'(checksum), CSUM_ON ? 32'h0231 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
